fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV32 core. Generates the PC and issues requests over a valid/ready instruction-memory interface, with one request outstanding at most.
- Buffers returned instructions in a 2-entry FIFO and presents them to decode with a valid/ready handshake.
- id_op feeds the Main_Decoder Op input directly.
- Accepts branch/jump redirects from execute and discards wrong-path fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- XLEN, 32, address and instruction width.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address; bits [1:0] always 0.
- imem_rsp_valid  in  1  instruction returned (earliest 1 cycle after request handshake).
- imem_rsp_data  in  XLEN  returned instruction word.
- redirect_valid  in  1  taken branch/jal/jalr from execute.
- redirect_pc  in  XLEN  redirect target.
- id_valid  out  1  instruction available to decode.
- id_ready  in  1  decode accepts instruction.
- id_instr  out  XLEN  FIFO-head instruction.
- id_pc  out  XLEN  PC of id_instr.
- id_pc_plus4  out  XLEN  id_pc + 4, modulo 2^32.
- id_op  out  7  id_instr[6:0].

Behaviour:
- State: pc (next fetch address), outstanding flag, req_addr (address of the outstanding request), kill flag, FIFO of {instr, pc} with depth 2 and count 0..2.
- Reset (async, immediate): pc=RESET_PC, outstanding=0, kill=0, count=0. Outputs: imem_req_valid=0, id_valid=0, id_instr=0, id_pc=0, id_pc_plus4=0, id_op=0, imem_req_addr=RESET_PC.
- A response arriving after reset while outstanding=0 is ignored.
- Definitions:
  - pop = id_valid & id_ready.
  - rsp_ok = imem_rsp_valid & outstanding.
- imem_req_valid = !rst & !redirect_valid & (!outstanding | rsp_ok) & (count + outstanding - pop < 2).
- imem_req_valid is combinational, and once asserted it is held until handshake unless redirect_valid rises.
- imem_req_addr = pc.
- Request handshake (imem_req_valid & imem_req_ready): req_addr<=pc, pc<=pc+4 (wraps), outstanding<=1.
- Response with rsp_ok & !kill: push {imem_rsp_data, req_addr} into FIFO. outstanding<=0 unless a new handshake occurs in the same cycle.
- Response with rsp_ok & kill: data dropped, kill<=0, outstanding<=0.
- imem_rsp_valid while outstanding=0: ignored.
- Push and pop in the same cycle: count unchanged.
- Push with count=2 is impossible by construction; a bench assertion enforces it.
- Redirect cycle:
  - pc<=redirect_pc & ~3.
  - FIFO flushed (count<=0; a pop in the same cycle is still valid for decode).
  - No request issued.
  - If outstanding and no response this cycle: kill<=1.
  - If the response arrives this cycle: it is dropped.
- Redirect overrides every simultaneous event. Repeated redirects each reload pc.
- Redirect while kill=1 keeps kill=1.
- Throughput: 1 instruction/cycle with 1-cycle memory and id_ready held high.
- Outputs are driven from the FIFO head. id_valid = (count != 0).
- id_instr/id_pc are stable while id_valid & !id_ready.

Test Plan:
- Reset, imem 1-cycle latency returning 32'h00000013 everywhere, id_ready=1 -> addresses 0,4,8,... on consecutive cycles; id_pc 0,4,8 one per cycle; id_op=7'h13.
- id_ready=0 for 5 cycles during streaming -> exactly 2 instructions buffered, imem_req_valid drops, no request lost; release -> id_pc continues in sequence without gaps.
- Request at 0x10 outstanding, redirect_valid with redirect_pc=0x103 the cycle before response -> response dropped, next request address 0x100, first id_pc=0x100.
- Redirect in the same cycle as the response and with a pop -> popped instruction consumed, response dropped, FIFO empty, fetch resumes at target.
- pc=0xFFFFFFFC -> next request 0x00000000; id_pc_plus4 for 0xFFFFFFFC = 0x00000000.
- Assert rst while a request is outstanding, then deliver the stale response -> ignored, first fetch at RESET_PC, id_valid stays 0 until the new response.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32 instruction-fetch stage: PC generation, one-outstanding imem request,
// 2-entry {instr, pc} buffer to decode, and redirect handling with wrong-path response kill.
module fetch_stage #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [6:0]      id_op
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_addr;
  logic            r_outstanding;
  logic            r_kill;
  logic [1:0]      r_count;
  logic            r_head;
  logic [XLEN-1:0] r_instr [2];
  logic [XLEN-1:0] r_ipc   [2];

  logic            w_pop;
  logic            w_rsp_ok;
  logic            w_push;
  logic            w_hs;
  logic            w_wr_idx;
  logic [2:0]      w_occ;
  logic [XLEN-1:0] w_head_instr;
  logic [XLEN-1:0] w_head_pc;

  assign w_pop    = id_valid & id_ready;
  assign w_rsp_ok = imem_rsp_valid & r_outstanding;
  assign w_push   = w_rsp_ok & ~r_kill & ~redirect_valid;
  // Slots already claimed after this cycle's pop; keeps count + outstanding <= 2.
  assign w_occ    = {1'b0, r_count} + {2'b00, r_outstanding} - {2'b00, w_pop};

  assign imem_req_valid = ~rst & ~redirect_valid & (~r_outstanding | w_rsp_ok) & (w_occ < 3'd2);
  assign imem_req_addr  = r_pc;
  assign w_hs           = imem_req_valid & imem_req_ready;

  assign w_wr_idx     = r_head ^ r_count[0];
  assign w_head_instr = r_instr[r_head];
  assign w_head_pc    = r_ipc[r_head];

  assign id_valid    = (r_count != 2'd0);
  assign id_instr    = id_valid ? w_head_instr : '0;
  assign id_pc       = id_valid ? w_head_pc : '0;
  assign id_pc_plus4 = id_valid ? w_head_pc + XLEN'(4) : '0;
  assign id_op       = id_instr[6:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_req_addr    <= RESET_PC;
      r_outstanding <= 1'b0;
      r_kill        <= 1'b0;
      r_count       <= 2'd0;
      r_head        <= 1'b0;
    end else if (redirect_valid) begin
      r_pc    <= {redirect_pc[XLEN-1:2], 2'b00};
      r_count <= 2'd0;
      if (w_pop) r_head <= ~r_head;
      // A response landing now is the wrong-path one; otherwise the next one must be killed.
      if (w_rsp_ok) begin
        r_outstanding <= 1'b0;
        r_kill        <= 1'b0;
      end else if (r_outstanding) begin
        r_kill <= 1'b1;
      end
    end else begin
      if (w_hs) begin
        r_req_addr <= r_pc;
        r_pc       <= r_pc + XLEN'(4);
      end
      if (w_hs)          r_outstanding <= 1'b1;
      else if (w_rsp_ok) r_outstanding <= 1'b0;
      if (w_rsp_ok & r_kill) r_kill <= 1'b0;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      if (w_pop) r_head <= ~r_head;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[w_wr_idx] <= imem_rsp_data;
      r_ipc[w_wr_idx]   <= r_req_addr;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with an imem model and
// a sequential-PC reference model of the instruction stream seen by decode.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [6:0]  id_op;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_op(id_op)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory / stream model state
  bit          pend, pend_kill;
  logic [31:0] pend_addr;
  int          lat, lat_lo, lat_hi;
  int          occ_n;
  logic [31:0] exp_fetch, exp_id_pc;
  bit          held;
  logic [31:0] held_addr;
  bit          const_mode;
  // Observations of the most recent step
  bit          last_hs, last_pop, last_rsp, last_rv, last_idv;
  logic [31:0] last_hs_addr, last_pop_pc, last_pop_p4;
  int          n_hs, n_pop;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (const_mode) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  task automatic model_reset();
    pend = 0; pend_kill = 0; lat = 0; occ_n = 0; held = 0;
    exp_fetch = 32'h0; exp_id_pc = 32'h0;
  endtask

  task automatic apply_reset();
    imem_req_ready = 0; id_ready = 0; redirect_valid = 0; imem_rsp_valid = 0;
    rst = 1;
    #1;
    checks += 6;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
    if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL rst_req_addr got %h exp 0", imem_req_addr); end
    if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid got %b exp 0", id_valid); end
    if (id_instr !== 32'h0) begin errors++; $display("FAIL rst_id_instr got %h exp 0", id_instr); end
    if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_id_pc got %h/%h exp 0/0", id_pc, id_pc_plus4); end
    if (id_op !== 7'h0) begin errors++; $display("FAIL rst_id_op got %h exp 0", id_op); end
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask

  task automatic step(input bit rq, input bit dq, input bit rd, input logic [31:0] rpc, input bit spur);
    bit resp, hs, pop;
    imem_req_ready = rq; id_ready = dq; redirect_valid = rd; redirect_pc = rpc;
    resp = pend && (lat == 0);
    if (resp) begin imem_rsp_valid = 1; imem_rsp_data = mem_word(pend_addr); end
    else if (!pend && spur) begin imem_rsp_valid = 1; imem_rsp_data = $urandom; end
    else begin imem_rsp_valid = 0; imem_rsp_data = $urandom; end
    @(negedge clk);
    hs  = imem_req_valid && rq;
    pop = id_valid && dq;
    if (rd) begin
      checks++;
      if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL req_during_redirect got %b exp 0", imem_req_valid); end
    end
    if (held && !rd) begin
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== held_addr) begin
        errors++; $display("FAIL req_hold got %b/%h exp 1/%h", imem_req_valid, imem_req_addr, held_addr);
      end
    end
    checks++;
    if (id_valid !== (occ_n != 0)) begin errors++; $display("FAIL id_valid got %b exp %b", id_valid, occ_n != 0); end
    if (id_valid === 1'b1) begin
      checks += 4;
      if (id_pc !== exp_id_pc) begin errors++; $display("FAIL id_pc got %h exp %h", id_pc, exp_id_pc); end
      if (id_instr !== mem_word(exp_id_pc)) begin errors++; $display("FAIL id_instr got %h exp %h", id_instr, mem_word(exp_id_pc)); end
      if (id_op !== id_instr[6:0]) begin errors++; $display("FAIL id_op got %h exp %h", id_op, id_instr[6:0]); end
      if (id_pc_plus4 !== exp_id_pc + 32'd4) begin errors++; $display("FAIL id_pc_plus4 got %h exp %h", id_pc_plus4, exp_id_pc + 32'd4); end
    end
    if (hs) begin
      checks++;
      if (imem_req_addr !== exp_fetch) begin errors++; $display("FAIL req_addr got %h exp %h", imem_req_addr, exp_fetch); end
    end
    last_hs = hs; last_pop = pop; last_rsp = resp; last_rv = imem_req_valid; last_idv = id_valid;
    last_hs_addr = imem_req_addr; last_pop_pc = id_pc; last_pop_p4 = id_pc_plus4;
    if (hs) n_hs++;
    if (pop) begin n_pop++; exp_id_pc += 32'd4; occ_n--; end
    if (resp) begin
      if (!pend_kill && !rd) occ_n++;
      pend = 0; pend_kill = 0;
    end else if (pend) begin
      if (rd) pend_kill = 1;
      if (lat > 0) lat--;
    end
    if (hs) begin
      pend = 1; pend_kill = 0; pend_addr = imem_req_addr;
      lat = $urandom_range(lat_hi, lat_lo);
      exp_fetch += 32'd4;
    end
    if (rd) begin exp_fetch = rpc & ~32'h3; exp_id_pc = rpc & ~32'h3; occ_n = 0; end
    checks++;
    if (occ_n > 2 || occ_n < 0) begin errors++; $display("FAIL fifo_occupancy got %0d exp 0..2", occ_n); end
    held = imem_req_valid && !rq; held_addr = imem_req_addr;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_stream();
    apply_reset();
    const_mode = 1; lat_lo = 0; lat_hi = 0; n_hs = 0; n_pop = 0;
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
    checks += 2;
    if (n_hs != 10) begin errors++; $display("FAIL stream_requests got %0d exp 10", n_hs); end
    if (n_pop != 8) begin errors++; $display("FAIL stream_pops got %0d exp 8", n_pop); end
    const_mode = 0;
  endtask

  task automatic test_stall();
    apply_reset();
    lat_lo = 0; lat_hi = 0;
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
    checks += 2;
    if (occ_n != 2) begin errors++; $display("FAIL stall_buffered got %0d exp 2", occ_n); end
    if (last_rv !== 1'b0) begin errors++; $display("FAIL stall_req_valid got %b exp 0", last_rv); end
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0);
  endtask

  task automatic test_redirect_before_rsp();
    int guard;
    apply_reset();
    lat_lo = 0; lat_hi = 0; guard = 0;
    while (exp_fetch != 32'h10 && guard < 20) begin step(1, 1, 0, 0, 0); guard++; end
    checks++;
    if (exp_fetch != 32'h10) begin errors++; $display("FAIL redir_setup_timeout got %h exp 00000010", exp_fetch); end
    lat_lo = 1; lat_hi = 1;
    step(1, 1, 0, 0, 0);
    lat_lo = 0; lat_hi = 0;
    checks++;
    if (!(pend && pend_addr == 32'h10)) begin errors++; $display("FAIL redir_outstanding got %h exp 00000010", pend_addr); end
    step(1, 1, 1, 32'h103, 0);
    step(1, 1, 0, 0, 0);
    checks++;
    if (!last_hs || last_hs_addr !== 32'h100) begin errors++; $display("FAIL redir_next_addr got %h exp 00000100", last_hs_addr); end
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    checks++;
    if (!last_pop || last_pop_pc !== 32'h100) begin errors++; $display("FAIL redir_first_id_pc got %h exp 00000100", last_pop_pc); end
  endtask

  task automatic test_redirect_with_rsp_pop();
    apply_reset();
    lat_lo = 0; lat_hi = 0;
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 32'h2000, 0);
    checks++;
    if (!(last_pop && last_rsp)) begin errors++; $display("FAIL redir_rsp_pop got %b%b exp 11", last_pop, last_rsp); end
    step(1, 1, 0, 0, 0);
    checks += 2;
    if (last_idv !== 1'b0) begin errors++; $display("FAIL redir_flush got %b exp 0", last_idv); end
    if (!last_hs || last_hs_addr !== 32'h2000) begin errors++; $display("FAIL redir_resume got %h exp 00002000", last_hs_addr); end
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
  endtask

  task automatic test_wrap();
    bit seen;
    logic [31:0] p4;
    apply_reset();
    lat_lo = 0; lat_hi = 0; seen = 0; p4 = 32'hx;
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    step(1, 1, 1, 32'hFFFF_FFF9, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    checks++;
    if (!last_hs || last_hs_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 00000000", last_hs_addr); end
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0, 0);
      if (last_pop && last_pop_pc == 32'hFFFF_FFFC) begin seen = 1; p4 = last_pop_p4; end
    end
    checks++;
    if (!seen || p4 !== 32'h0) begin errors++; $display("FAIL wrap_pc_plus4 got %h exp 00000000", p4); end
  endtask

  task automatic test_reset_outstanding();
    int guard;
    apply_reset();
    lat_lo = 3; lat_hi = 3; guard = 0;
    step(1, 1, 0, 0, 0);
    while (!pend && guard < 10) begin step(1, 1, 0, 0, 0); guard++; end
    checks++;
    if (!pend) begin errors++; $display("FAIL rst_out_setup got %b exp 1", pend); end
    apply_reset();
    lat_lo = 0; lat_hi = 0;
    step(0, 1, 0, 0, 1);
    checks++;
    if (last_rv !== 1'b1 || last_hs_addr !== 32'h0) begin errors++; $display("FAIL rst_out_first_req got %b/%h exp 1/00000000", last_rv, last_hs_addr); end
    step(1, 1, 0, 0, 0);
    checks++;
    if (last_idv !== 1'b0) begin errors++; $display("FAIL rst_out_stale got %b exp 0", last_idv); end
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
  endtask

  task automatic test_random();
    apply_reset();
    lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
           $urandom, $urandom_range(0, 7) == 0);
  endtask

  initial begin
    const_mode = 0; lat_lo = 0; lat_hi = 0;
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_redirect_before_rsp();
    test_redirect_with_rsp_pop();
    test_wrap();
    test_reset_outstanding();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
